// File: rtl/mips_mem_pkg.sv
// Shared definitions for the MIPS data-memory responder: FSM state encoding,
// word size and the byte-address to word-index helper.
package mips_mem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } mem_state_t;

    localparam int WORD_BYTES = 4;

    // Word index of a byte address relative to the base of the array. The
    // subtraction wraps, so addresses below base land far above any depth.
    function automatic logic [31:0] word_index(input logic [31:0] addr,
                                               input logic [31:0] base);
        logic [31:0] offset;
        offset = addr - base;
        return offset >> $clog2(WORD_BYTES);
    endfunction

endpackage

// File: rtl/data_ram_bank.sv
// DEPTH x 32 storage with per-byte write enables and a registered read port.
module data_ram_bank
    import mips_mem_pkg::*;
#(
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] idx,
    input  logic [3:0]        wr_be,
    input  logic [31:0]       wr_data,
    output logic [31:0]       rd_data
);

    logic [31:0] mem [DEPTH];

    // Byte-lane writes and registered reads share one word index.
    // NOTE: the array has no reset branch on purpose; resetting a RAM would
    // turn it into a huge flop bank instead of a memory macro.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < WORD_BYTES; b++) begin
                if (wr_be[b]) begin
                    mem[idx][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
        if (rd_en) begin
            rd_data <= mem[idx];
        end
    end

endmodule

// File: rtl/harvard_data_mem_responder.sv
// Data-memory responder for the Harvard MIPS core: latches one request,
// holds the core in waitrequest for LATENCY cycles, then completes the
// access against the RAM bank in a single DONE cycle.
module harvard_data_mem_responder
    import mips_mem_pkg::*;
#(
    parameter int          DEPTH     = 1024,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          LATENCY   = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] data_address,
    input  logic        data_read,
    input  logic        data_write,
    input  logic [3:0]  data_byteenable,
    input  logic [31:0] data_writedata,
    output logic [31:0] data_readdata,
    output logic        data_waitrequest,
    output logic        data_err
);

    localparam int         ADDR_W       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] COUNT_INIT   = 4'(LATENCY - 1);
    localparam bit         SINGLE_CYCLE = (LATENCY == 1);

    mem_state_t  state;
    logic [3:0]  count;
    logic [31:0] lat_addr;
    logic        lat_read;
    logic        lat_write;
    logic [3:0]  lat_be;
    logic [31:0] lat_wdata;
    logic        rd_from_ram;

    logic              req;
    logic              in_idle;
    logic [31:0]       cur_addr;
    logic              cur_read;
    logic              cur_write;
    logic [3:0]        cur_be;
    logic [31:0]       cur_wdata;
    logic [31:0]       idx_full;
    logic              illegal;
    logic              enter_done;
    logic              ram_we;
    logic              ram_re;
    logic [31:0]       ram_rdata;

    assign req     = data_read | data_write;
    assign in_idle = (state == IDLE);

    // With LATENCY==1 the access commits on the same edge that would latch the
    // request, so the live inputs are used in IDLE and the latches afterwards.
    assign cur_addr  = in_idle ? data_address    : lat_addr;
    assign cur_read  = in_idle ? data_read       : lat_read;
    assign cur_write = in_idle ? data_write      : lat_write;
    assign cur_be    = in_idle ? data_byteenable : lat_be;
    assign cur_wdata = in_idle ? data_writedata  : lat_wdata;

    // Word offset >= DEPTH is the same test as byte offset >= DEPTH*4.
    assign idx_full = word_index(cur_addr, BASE_ADDR);
    assign illegal  = (cur_read & cur_write)
                    | (cur_addr[1:0] != 2'b00)
                    | (idx_full >= 32'(DEPTH));

    assign enter_done = (in_idle & req & SINGLE_CYCLE)
                      | ((state == BUSY) & (count == 4'd1));

    assign ram_we = enter_done & cur_write & ~illegal;
    assign ram_re = enter_done & cur_read  & ~illegal;

    assign data_waitrequest = reset | (in_idle & req) | (state == BUSY);

    // Read data comes straight from the RAM's output register; the flag forces
    // zero after reset or an illegal access until the next legal read.
    assign data_readdata = rd_from_ram ? ram_rdata : 32'h0000_0000;

    data_ram_bank #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .wr_en   (ram_we),
        .rd_en   (ram_re),
        .idx     (idx_full[ADDR_W-1:0]),
        .wr_be   (cur_be),
        .wr_data (cur_wdata),
        .rd_data (ram_rdata)
    );

    // Request capture; data-path registers need no reset.
    always_ff @(posedge clk) begin
        if (in_idle && req) begin
            lat_addr  <= data_address;
            lat_read  <= data_read;
            lat_write <= data_write;
            lat_be    <= data_byteenable;
            lat_wdata <= data_writedata;
        end
    end

    // Access sequencer: IDLE -> BUSY (LATENCY-1 cycles) -> DONE -> IDLE.
    // NOTE: every state register here uses <= so all of them update from the
    // same pre-edge values; a blocking = would leak new values into later lines.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            count       <= 4'd0;
            data_err    <= 1'b0;
            rd_from_ram <= 1'b0;
        end else begin
            data_err <= enter_done & illegal;
            if (enter_done) begin
                if (illegal) begin
                    rd_from_ram <= 1'b0;
                end else if (cur_read) begin
                    rd_from_ram <= 1'b1;
                end
            end
            // NOTE: the default arm keeps the case full, so an unused encoding
            // recovers to IDLE instead of leaving logic undefined.
            case (state)
                IDLE: begin
                    if (req) begin
                        count <= COUNT_INIT;
                        state <= SINGLE_CYCLE ? DONE : BUSY;
                    end
                end
                BUSY: begin
                    count <= count - 4'd1;
                    if (count == 4'd1) begin
                        state <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_harvard_data_mem_responder.sv
// Scoreboard bench for harvard_data_mem_responder at LATENCY 1, 2 and 15.
// Drivers push the expected response when a request is issued; a monitor
// pops and compares whenever a responder completes (request high, wait low).
module tb_harvard_data_mem_responder;

    typedef struct {
        int          dut;
        bit          chk_data;
        logic [31:0] data;
        bit          err;
        int          issue;
    } exp_t;

    logic        clk;
    logic        reset;
    logic [31:0] address [3];
    logic        rd      [3];
    logic        wr      [3];
    logic [3:0]  byteen  [3];
    logic [31:0] wdata   [3];
    logic [31:0] rdata   [3];
    logic        wreq    [3];
    logic        err     [3];

    int   lat_tab   [3] = '{1, 2, 15};
    bit   prev_done [3];
    exp_t sb [$];
    int   cycle;
    int   checks;
    int   errors;

    harvard_data_mem_responder #(.DEPTH(1024), .BASE_ADDR(32'h0000_0000), .LATENCY(1)) u_lat1 (
        .clk(clk), .reset(reset), .data_address(address[0]), .data_read(rd[0]),
        .data_write(wr[0]), .data_byteenable(byteen[0]), .data_writedata(wdata[0]),
        .data_readdata(rdata[0]), .data_waitrequest(wreq[0]), .data_err(err[0]));

    harvard_data_mem_responder #(.DEPTH(1024), .BASE_ADDR(32'h0000_0000), .LATENCY(2)) u_lat2 (
        .clk(clk), .reset(reset), .data_address(address[1]), .data_read(rd[1]),
        .data_write(wr[1]), .data_byteenable(byteen[1]), .data_writedata(wdata[1]),
        .data_readdata(rdata[1]), .data_waitrequest(wreq[1]), .data_err(err[1]));

    harvard_data_mem_responder #(.DEPTH(1024), .BASE_ADDR(32'h0000_4000), .LATENCY(15)) u_lat15 (
        .clk(clk), .reset(reset), .data_address(address[2]), .data_read(rd[2]),
        .data_write(wr[2]), .data_byteenable(byteen[2]), .data_writedata(wdata[2]),
        .data_readdata(rdata[2]), .data_waitrequest(wreq[2]), .data_err(err[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Completion monitor: pops one expectation per DONE cycle of any responder.
    always @(negedge clk) begin : monitor
        exp_t e;
        for (int d = 0; d < 3; d++) begin
            if (prev_done[d]) check("err_pulse", 32'(err[d]), 32'd0);
            prev_done[d] = 1'b0;
            if (!reset && (rd[d] || wr[d]) && !wreq[d]) begin
                prev_done[d] = 1'b1;
                if (sb.size() == 0) begin
                    check("sb_unexpected", 32'(sb.size()), 32'd1);
                end else begin
                    e = sb.pop_front();
                    check("sb_dut", 32'(d), 32'(e.dut));
                    check("err", 32'(err[d]), 32'(e.err));
                    if (e.chk_data) check("rdata", rdata[d], e.data);
                    check("latency", 32'(cycle - e.issue + 1), 32'(lat_tab[d] + 1));
                end
            end
        end
    end

    // Issue one access; caller is just after a rising edge. Returns just
    // after the edge that leaves DONE, so calls chain back-to-back.
    task automatic access(input int d, input bit r, input bit w, input logic [31:0] a,
                          input logic [3:0] be, input logic [31:0] wd,
                          input logic [31:0] exp_rd, input bit exp_err);
        exp_t e;
        bit   done;
        e.dut      = d;
        e.chk_data = r | exp_err;
        e.data     = exp_err ? 32'h0 : exp_rd;
        e.err      = exp_err;
        e.issue    = cycle;
        sb.push_back(e);
        address[d] = a;
        rd[d]      = r;
        wr[d]      = w;
        byteen[d]  = be;
        wdata[d]   = wd;
        done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (!wreq[d]) done = 1'b1;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL timeout: dut %0d addr %h never completed", d, a);
            sb.delete(sb.size() - 1);
        end
        @(posedge clk);
        #1;
        rd[d] = 1'b0;
        wr[d] = 1'b0;
    endtask

    // Fill 16 words, then 50 random back-to-back reads/writes against a model.
    task automatic rand_phase(input int d, input logic [31:0] base);
        logic [31:0] model [16];
        logic [31:0] a;
        logic [31:0] wd;
        logic [3:0]  be;
        int          k;
        for (int i = 0; i < 16; i++) begin
            model[i] = 32'hA500_0000 ^ (32'(i) * 32'h0101_0101) ^ 32'(d);
            access(d, 1'b0, 1'b1, base + 32'(i * 4), 4'hF, model[i], 32'h0, 1'b0);
        end
        for (int n = 0; n < 50; n++) begin
            k = int'($urandom_range(15));
            a = base + 32'(k * 4);
            if ($urandom_range(1) == 1) begin
                access(d, 1'b1, 1'b0, a, 4'h0, 32'h0, model[k], 1'b0);
            end else begin
                be = 4'($urandom_range(15));
                wd = $urandom;
                access(d, 1'b0, 1'b1, a, be, wd, 32'h0, 1'b0);
                for (int b = 0; b < 4; b++) begin
                    if (be[b]) model[k][8*b +: 8] = wd[8*b +: 8];
                end
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        cycle  = 0;
        for (int d = 0; d < 3; d++) begin
            address[d]   = 32'h0;
            rd[d]        = 1'b0;
            wr[d]        = 1'b0;
            byteen[d]    = 4'h0;
            wdata[d]     = 32'h0;
            prev_done[d] = 1'b0;
        end
        reset = 1'b1;

        // Reset state of all three responders.
        @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            check("rst_rdata", rdata[d], 32'h0);
            check("rst_err", 32'(err[d]), 32'd0);
            check("rst_wait", 32'(wreq[d]), 32'd1);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        for (int d = 0; d < 3; d++) check("idle_wait", 32'(wreq[d]), 32'd0);
        @(posedge clk);
        #1;

        // LATENCY=2: full write then readback.
        access(1, 1'b0, 1'b1, 32'h8, 4'hF, 32'h1234_5678, 32'h0, 1'b0);
        access(1, 1'b1, 1'b0, 32'h8, 4'h0, 32'h0, 32'h1234_5678, 1'b0);

        // Partial byte-lane write.
        access(1, 1'b0, 1'b1, 32'h20, 4'hF, 32'h1122_3344, 32'h0, 1'b0);
        access(1, 1'b0, 1'b1, 32'h20, 4'b0101, 32'hAABB_CCDD, 32'h0, 1'b0);
        access(1, 1'b1, 1'b0, 32'h20, 4'h0, 32'h0, 32'h11BB_33DD, 1'b0);

        // Reset in the middle of a write: the old value must survive.
        access(1, 1'b0, 1'b1, 32'h10, 4'hF, 32'h0BAD_F00D, 32'h0, 1'b0);
        address[1] = 32'h10;
        wdata[1]   = 32'hDEAD_BEEF;
        byteen[1]  = 4'hF;
        wr[1]      = 1'b1;
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check("midrst_wait", 32'(wreq[1]), 32'd1);
        @(posedge clk);
        #1;
        wr[1] = 1'b0;
        reset = 1'b0;
        #1;
        check("midrst_idle", 32'(wreq[1]), 32'd0);
        @(posedge clk);
        #1;
        access(1, 1'b1, 1'b0, 32'h10, 4'h0, 32'h0, 32'h0BAD_F00D, 1'b0);

        // Illegal accesses: out of range, misaligned; RAM left unchanged.
        access(1, 1'b0, 1'b1, 32'h0, 4'hF, 32'h00C0_FFEE, 32'h0, 1'b0);
        access(1, 1'b0, 1'b1, 32'h1000, 4'hF, 32'hFFFF_FFFF, 32'h0, 1'b1);
        access(1, 1'b1, 1'b0, 32'h0, 4'h0, 32'h0, 32'h00C0_FFEE, 1'b0);
        access(1, 1'b1, 1'b0, 32'h6, 4'h0, 32'h0, 32'h0, 1'b1);
        access(1, 1'b1, 1'b0, 32'h1000, 4'h0, 32'h0, 32'h0, 1'b1);
        access(1, 1'b0, 1'b1, 32'hA, 4'hF, 32'h0, 32'h0, 1'b1);
        access(1, 1'b1, 1'b0, 32'h8, 4'h0, 32'h0, 32'h1234_5678, 1'b0);

        // Zero byteenable is a legal no-op; read+write together is illegal.
        access(1, 1'b0, 1'b1, 32'h8, 4'h0, 32'hFFFF_FFFF, 32'h0, 1'b0);
        access(1, 1'b1, 1'b1, 32'h8, 4'hF, 32'hFFFF_FFFF, 32'h0, 1'b1);
        access(1, 1'b1, 1'b0, 32'h8, 4'h0, 32'h0, 32'h1234_5678, 1'b0);

        // Non-zero base: wrap below base and one past the top are illegal.
        access(2, 1'b0, 1'b1, 32'h0000_4FFC, 4'hF, 32'h5A5A_5A5A, 32'h0, 1'b0);
        access(2, 1'b1, 1'b0, 32'h0000_4FFC, 4'h0, 32'h0, 32'h5A5A_5A5A, 1'b0);
        access(2, 1'b1, 1'b0, 32'h0000_3FFC, 4'h0, 32'h0, 32'h0, 1'b1);
        access(2, 1'b1, 1'b0, 32'h0000_5000, 4'h0, 32'h0, 32'h0, 1'b1);

        // Random back-to-back traffic at the latency extremes.
        rand_phase(0, 32'h0000_0000);
        rand_phase(2, 32'h0000_4000);

        repeat (3) @(posedge clk);
        #1;
        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
